// File: rtl/uart_io_pkg.sv
// ---------------------------------------------------------------------------
// uart_io_pkg : shared types and sizing helpers for uart_word_io
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_io_pkg;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_LOAD  = 3'd1,
    T_START = 3'd2,
    T_GUARD = 3'd3,
    T_WAIT  = 3'd4
  } tx_state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  function automatic int unsigned calc_nb(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock first-word-fall-through FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // The extra MSB tells full (MSBs differ) from empty (pointers equal).
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_word_io.sv
// ---------------------------------------------------------------------------
// uart_word_io : word <-> byte bridge between a CPU and a byte UART
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_word_io
  import uart_io_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              byte_mode,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic [7:0]        rx_byte,
  input  logic              rx_ready,
  input  logic              rx_ferr,
  input  logic              clear_err,
  output logic              rx_overflow,
  output logic              rx_frame_err
);

  localparam int unsigned NB    = calc_nb(DATA_W);
  localparam int unsigned CNT_W = $clog2(NB + 1);

  logic              tx_full, tx_empty, tx_pop;
  logic [DATA_W-1:0] tx_dout;
  logic              rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(wr_valid), .pop(tx_pop),
    .din(wr_data), .full(tx_full), .empty(tx_empty), .dout(tx_dout)
  );

  logic              done_q, done_d;
  logic [DATA_W-1:0] done_word_q, done_word_d;

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(done_q), .pop(rd_ready),
    .din(done_word_q), .full(rx_full), .empty(rx_empty), .dout(rx_dout)
  );

  assign wr_ready = !tx_full;
  assign rd_valid = !rx_empty;
  assign rd_data  = rx_empty ? '0 : rx_dout;

  // ---------------- TX serialiser ----------------
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              tx_bmode_q, tx_bmode_d;
  logic [7:0]        tx_byte_q, tx_byte_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rem_d      = rem_q;
    tx_bmode_d = tx_bmode_q;
    tx_byte_d  = tx_byte_q;
    tx_pop     = 1'b0;
    tx_start   = 1'b0;
    shifted    = LSB_FIRST ? (shreg_q >> 8) : (shreg_q << 8);
    case (state_q)
      T_IDLE: if (!tx_empty) state_d = T_LOAD;
      T_LOAD: begin
        tx_pop     = 1'b1;
        shreg_d    = tx_dout;
        tx_bmode_d = byte_mode;
        rem_d      = byte_mode ? CNT_W'(1) : CNT_W'(NB);
        // Byte mode always sends the low byte, whatever the wire order.
        tx_byte_d  = (byte_mode || LSB_FIRST) ? tx_dout[7:0] : tx_dout[DATA_W-1 -: 8];
        state_d    = T_START;
      end
      T_START: if (!tx_busy) begin
        tx_start = 1'b1;
        state_d  = T_GUARD;
      end
      T_GUARD: state_d = T_WAIT;
      T_WAIT: if (!tx_busy) begin
        rem_d = rem_q - CNT_W'(1);
        if (tx_bmode_q || rem_q == CNT_W'(1)) begin
          state_d = tx_empty ? T_IDLE : T_LOAD;
        end else begin
          shreg_d   = shifted;
          tx_byte_d = LSB_FIRST ? shifted[7:0] : shifted[DATA_W-1 -: 8];
          state_d   = T_START;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign tx_byte = tx_byte_q;

  // ---------------- RX assembler ----------------
  logic [CNT_W-1:0]  cnt_q, cnt_d, pos, target;
  logic              rx_bmode_q, rx_bmode_d, bmode_eff;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              ovf_q, ovf_d, ferr_q, ferr_d;

  always_comb begin
    cnt_d       = cnt_q;
    rx_bmode_d  = rx_bmode_q;
    asm_d       = asm_q;
    done_d      = 1'b0;
    done_word_d = done_word_q;
    bmode_eff   = (cnt_q == '0) ? byte_mode : rx_bmode_q;
    target      = bmode_eff ? CNT_W'(1) : CNT_W'(NB);
    pos         = (LSB_FIRST || bmode_eff) ? cnt_q : (CNT_W'(NB - 1) - cnt_q);
    if (rx_ready) begin
      if (rx_ferr) begin
        cnt_d = '0;
        asm_d = '0;
      end else begin
        if (cnt_q == '0) rx_bmode_d = byte_mode;
        for (int unsigned i = 0; i < NB; i++) begin
          if (pos == CNT_W'(i)) asm_d[i*8 +: 8] = rx_byte;
        end
        if ((cnt_q + CNT_W'(1)) == target) begin
          done_d      = 1'b1;
          done_word_d = asm_d;
          asm_d       = '0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    // A set event in the same cycle as clear_err takes priority.
    ovf_d  = (done_q && rx_full)  ? 1'b1 : (clear_err ? 1'b0 : ovf_q);
    ferr_d = (rx_ready && rx_ferr) ? 1'b1 : (clear_err ? 1'b0 : ferr_q);
  end

  assign rx_overflow  = ovf_q;
  assign rx_frame_err = ferr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= T_IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      tx_bmode_q  <= 1'b0;
      tx_byte_q   <= '0;
      cnt_q       <= '0;
      rx_bmode_q  <= 1'b0;
      asm_q       <= '0;
      done_q      <= 1'b0;
      done_word_q <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      tx_bmode_q  <= tx_bmode_d;
      tx_byte_q   <= tx_byte_d;
      cnt_q       <= cnt_d;
      rx_bmode_q  <= rx_bmode_d;
      asm_q       <= asm_d;
      done_q      <= done_d;
      done_word_q <= done_word_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_word_io.sv
// ---------------------------------------------------------------------------
// tb_uart_word_io : self-checking bench for uart_word_io (DATA_W=32, DEPTH=4)
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_io;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        byte_mode = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_ready = 1'b0;
  logic        rx_ferr = 1'b0;
  logic        clear_err = 1'b0;
  logic        tx_busy;

  logic        wr_ready, rd_valid, tx_start, rx_overflow, rx_frame_err;
  logic [31:0] rd_data;
  logic [7:0]  tx_byte;

  logic        b_wr_ready, b_rd_valid, b_tx_start, b_rx_overflow, b_rx_frame_err;
  logic [31:0] b_rd_data;
  logic [7:0]  b_tx_byte;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_word_io #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .byte_mode(byte_mode),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .clear_err(clear_err), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err)
  );

  uart_word_io #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rstn(rstn), .byte_mode(byte_mode),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready),
    .tx_byte(b_tx_byte), .tx_start(b_tx_start), .tx_busy(1'b0),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
    .clear_err(clear_err), .rx_overflow(b_rx_overflow), .rx_frame_err(b_rx_frame_err)
  );

  // uart_tx stand-in: busy for BUSY_CYC cycles after each start; logs starts.
  int         busy_cnt = 0;
  int         cyc = 0;
  logic [7:0] seen_q[$];
  int         seen_cyc[$];
  int         start_while_busy = 0;

  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      seen_q.push_back(tx_byte);
      seen_cyc.push_back(cyc);
      if (tx_busy) start_while_busy++;
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Behavioural reference: TX byte stream and RX word queue, LSB-first instance.
  logic [7:0]  exp_tx[$];
  logic [31:0] m_fifo[$];
  int          m_cnt = 0;
  logic        m_bm = 1'b0;
  logic [31:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  logic        m_ferr = 1'b0;

  task automatic model_reset();
    m_fifo.delete();
    m_cnt = 0; m_acc = '0; m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_tx(input logic [31:0] w, input logic bm);
    if (bm) exp_tx.push_back(w[7:0]);
    else for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic model_rx(input logic [7:0] b, input logic fe);
    if (fe) begin
      m_cnt = 0; m_acc = '0; m_ferr = 1'b1;
    end else begin
      if (m_cnt == 0) m_bm = byte_mode;
      m_acc[8*m_cnt +: 8] = b;
      m_cnt++;
      if (m_cnt == (m_bm ? 1 : 4)) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(m_acc);
        else m_ovf = 1'b1;
        m_cnt = 0; m_acc = '0;
      end
    end
  endtask

  task automatic write_word(input logic [31:0] w, output int acc_cyc);
    int guard = 0;
    @(negedge clk);
    while (!wr_ready && guard < 500) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 500) begin
      failures++;
      $display("FAIL wr_ready_timeout: got wr_ready=%b expected 1 within 500 cycles", wr_ready);
    end
    wr_data = w; wr_valid = 1'b1; acc_cyc = cyc;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int guard = 0;
    while (seen_q.size() < n && guard < 3000) begin @(negedge clk); guard++; end
    repeat (40) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_byte = b; rx_ready = 1'b1; rx_ferr = fe;
    model_rx(b, fe);
    @(negedge clk);
    rx_ready = 1'b0; rx_ferr = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
    m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    if (m_fifo.size() > 0) void'(m_fifo.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_byte !== 8'h0) begin failures++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL reset_rx_overflow: got %b expected 0", rx_overflow); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_rx_frame_err: got %b expected 0", rx_frame_err); end
    rstn = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL idle_tx_start: got %b expected 0", tx_start); end
  endtask

  task automatic test_tx_word();
    int acc;
    seen_q.delete(); seen_cyc.delete(); exp_tx.delete(); start_while_busy = 0;
    byte_mode = 1'b0;
    model_tx(32'h11223344, 1'b0);
    write_word(32'h11223344, acc);
    wait_tx(exp_tx.size());
    checks++;
    if (seen_q.size() != exp_tx.size()) begin
      failures++; $display("FAIL tx_word_count: got %0d expected %0d", seen_q.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < seen_q.size(); i++) begin
      checks++;
      if (seen_q[i] !== exp_tx[i]) begin
        failures++; $display("FAIL tx_word_byte%0d: got %h expected %h", i, seen_q[i], exp_tx[i]);
      end
    end
    checks++;
    if (seen_cyc.size() == 0 || seen_cyc[0] != acc + 3) begin
      failures++; $display("FAIL tx_latency: got cycle %0d expected %0d", (seen_cyc.size() > 0) ? seen_cyc[0] : -1, acc + 3);
    end
    checks++;
    if (start_while_busy != 0) begin
      failures++; $display("FAIL tx_start_while_busy: got %0d expected 0", start_while_busy);
    end
  endtask

  task automatic test_byte_mode_tx();
    int acc;
    seen_q.delete(); seen_cyc.delete(); exp_tx.delete(); start_while_busy = 0;
    byte_mode = 1'b1;
    model_tx(32'hABCDEF5A, 1'b1);
    write_word(32'hABCDEF5A, acc);
    wait_tx(exp_tx.size());
    byte_mode = 1'b0;
    model_tx(32'h01020304, 1'b0);
    write_word(32'h01020304, acc);
    wait_tx(exp_tx.size());
    checks++;
    if (seen_q.size() != exp_tx.size()) begin
      failures++; $display("FAIL bmode_tx_count: got %0d expected %0d", seen_q.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < seen_q.size(); i++) begin
      checks++;
      if (seen_q[i] !== exp_tx[i]) begin
        failures++; $display("FAIL bmode_tx_byte%0d: got %h expected %h", i, seen_q[i], exp_tx[i]);
      end
    end
  endtask

  task automatic test_tx_random();
    int acc;
    logic [31:0] w;
    for (int pass = 0; pass < 2; pass++) begin
      seen_q.delete(); seen_cyc.delete(); exp_tx.delete(); start_while_busy = 0;
      byte_mode = pass[0] ^ $urandom_range(0, 1);
      for (int k = 0; k < 6; k++) begin
        w = $urandom;
        model_tx(w, byte_mode);
        write_word(w, acc);
      end
      wait_tx(exp_tx.size());
      checks++;
      if (seen_q.size() != exp_tx.size()) begin
        failures++; $display("FAIL tx_rand_count: got %0d expected %0d", seen_q.size(), exp_tx.size());
      end
      for (int i = 0; i < exp_tx.size() && i < seen_q.size(); i++) begin
        checks++;
        if (seen_q[i] !== exp_tx[i]) begin
          failures++; $display("FAIL tx_rand_byte%0d: got %h expected %h", i, seen_q[i], exp_tx[i]);
        end
      end
      checks++;
      if (start_while_busy != 0) begin
        failures++; $display("FAIL tx_rand_busy: got %0d expected 0", start_while_busy);
      end
    end
    byte_mode = 1'b0;
  endtask

  task automatic test_rx_word();
    byte_mode = 1'b0;
    send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rx_word_valid: got %b expected 1", rd_valid); end
    checks++;
    if (m_fifo.size() == 0 || rd_data !== m_fifo[0]) begin
      failures++; $display("FAIL rx_word_data: got %h expected %h", rd_data, (m_fifo.size() > 0) ? m_fifo[0] : 32'hx);
    end
    checks++;
    if (b_rd_data !== 32'h78563412) begin
      failures++; $display("FAIL rx_word_msb_first: got %h expected 78563412", b_rd_data);
    end
    pop_one();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rx_word_popped: got %b expected 0", rd_valid); end
  endtask

  task automatic test_rx_overflow();
    byte_mode = 1'b0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) send_byte(8'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_overflow !== m_ovf) begin
      failures++; $display("FAIL rx_ovf_flag: got %b expected %b", rx_overflow, m_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || m_fifo.size() == 0 || rd_data !== m_fifo[0]) begin
        failures++; $display("FAIL rx_ovf_word%0d: got valid=%b data=%h expected %h", k, rd_valid, rd_data,
                             (m_fifo.size() > 0) ? m_fifo[0] : 32'hx);
      end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rx_ovf_fifth_absent: got %b expected 0", rd_valid); end
    do_clear();
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL rx_ovf_clear: got %b expected 0", rx_overflow); end
  endtask

  task automatic test_frame_err();
    byte_mode = 1'b0;
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    send_byte(8'hEE, 1'b1);
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || m_fifo.size() != 1 || rd_data !== m_fifo[0]) begin
      failures++; $display("FAIL ferr_word: got valid=%b data=%h expected 04030201", rd_valid, rd_data);
    end
    checks++; if (rx_frame_err !== m_ferr) begin failures++; $display("FAIL ferr_flag: got %b expected %b", rx_frame_err, m_ferr); end
    pop_one();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ferr_single_word: got %b expected 0", rd_valid); end
    do_clear();
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", rx_frame_err); end
    @(negedge clk);
    rx_byte = 8'h55; rx_ready = 1'b1; rx_ferr = 1'b1; clear_err = 1'b1;
    model_rx(8'h55, 1'b1);
    @(negedge clk);
    rx_ready = 1'b0; rx_ferr = 1'b0; clear_err = 1'b0;
    checks++; if (rx_frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set_wins: got %b expected 1", rx_frame_err); end
    do_clear();
  endtask

  task automatic test_rx_byte_mode();
    byte_mode = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0);
    byte_mode = 1'b0;
    send_byte(8'($urandom), 1'b0);
    byte_mode = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b0);
    byte_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_fifo.size() != 4) begin
      failures++; $display("FAIL rx_bmode_model_words: got %0d expected 4", m_fifo.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_valid !== 1'b1 || m_fifo.size() == 0 || rd_data !== m_fifo[0]) begin
        failures++; $display("FAIL rx_bmode_word%0d: got valid=%b data=%h expected %h", k, rd_valid, rd_data,
                             (m_fifo.size() > 0) ? m_fifo[0] : 32'hx);
      end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rx_bmode_empty: got %b expected 0", rd_valid); end
  endtask

  task automatic test_reset_mid_tx();
    int acc, guard, n0;
    byte_mode = 1'b0;
    send_byte(8'h5A, 1'b1);
    for (int j = 0; j < 4; j++) send_byte(8'($urandom), 1'b0);
    seen_q.delete(); seen_cyc.delete();
    for (int k = 0; k < 3; k++) write_word($urandom, acc);
    guard = 0;
    while (seen_q.size() < 1 && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (seen_q.size() < 1) begin failures++; $display("FAIL rst_mid_first_start: got 0 starts expected 1"); end
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    n0 = seen_q.size();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL rst_mid_rd_data: got %h expected 0", rd_data); end
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_ovf: got %b expected 0", rx_overflow); end
    checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL rst_mid_ferr: got %b expected 0", rx_frame_err); end
    repeat (200) @(negedge clk);
    checks++;
    if (seen_q.size() != n0) begin
      failures++; $display("FAIL rst_mid_no_start: got %0d starts expected %0d", seen_q.size(), n0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_word();
    test_byte_mode_tx();
    test_tx_random();
    test_rx_word();
    test_rx_overflow();
    test_frame_err();
    test_rx_byte_mode();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_word_io.md
UART_WORD_IO -- requirements
Module: uart_word_io

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the word width; it must be a multiple of 8, and NB = DATA_W/8.
REQ-002 SHALL have parameter DEPTH, default 16, giving entries per FIFO; it must be a power of 2 and at least 2.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = byte 0 (bits 7:0) goes on the wire first, 0 = MSB byte first.
REQ-004 SHALL use one clock and a synchronous, active-low reset, with ports named clk and rstn.
REQ-005 clk  in  1  system clock; all logic on posedge.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 byte_mode  in  1  1 = each word carries one byte (zero-extended on RX, low byte only on TX); 0 = NB bytes per word.
REQ-008 wr_data  in  DATA_W  TX word from the CPU.
REQ-009 wr_valid  in  1  TX word offered.
REQ-010 wr_ready  out  1  TX FIFO not full.
REQ-011 rd_data  out  DATA_W  head of the RX FIFO, first-word-fall-through.
REQ-012 rd_valid  out  1  RX FIFO not empty.
REQ-013 rd_ready  in  1  pop the RX head.
REQ-014 tx_byte  out  8  byte to uart_tx.
REQ-015 tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-016 tx_busy  in  1  uart_tx busy.
REQ-017 rx_byte  in  8  byte from uart_rx.
REQ-018 rx_ready  in  1  one-cycle byte-valid strobe from uart_rx.
REQ-019 rx_ferr  in  1  framing error, qualified by rx_ready.
REQ-020 clear_err  in  1  clear the sticky error flags.
REQ-021 rx_overflow  out  1  sticky: a completed RX word was dropped.
REQ-022 rx_frame_err  out  1  sticky: a framing error occurred.

Function
REQ-023 Both FIFOs SHALL be DEPTH deep; a push is accepted only when not full, and a pop only when not empty.
REQ-024 A simultaneous push and pop on a non-empty FIFO SHALL leave the count unchanged.
REQ-025 A push into an empty FIFO SHALL make the word visible on the following cycle, with no bypass.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-027 The TX FSM SHALL have states T_IDLE, T_LOAD, T_START, T_GUARD and T_WAIT.
REQ-028 T_IDLE SHALL go to T_LOAD when the TX FIFO is non-empty; T_LOAD pops the head into a shift register, latches byte_mode, and sets remaining = 1 (byte_mode) or NB.
REQ-029 T_START SHALL drive tx_byte and assert tx_start for exactly one cycle when tx_busy = 0, otherwise it waits in T_START.
REQ-030 T_GUARD SHALL last one cycle and then go to T_WAIT; T_WAIT exits when tx_busy = 0, decrements remaining, and shifts the next byte in.
REQ-031 When remaining reaches 0, the TX FSM SHALL go to T_IDLE, or directly to T_LOAD if the TX FIFO is non-empty.
REQ-032 Latency: a word accepted at cycle N on an idle block SHALL give tx_start at N+3 (N+1 FIFO visible, N+2 T_LOAD, N+3 T_START).
REQ-033 The RX assembler SHALL, on rx_ready with rx_ferr = 0, place the byte at byte position cnt (mirrored if LSB_FIRST = 0) and increment cnt.
REQ-034 The RX assembler SHALL latch byte_mode when cnt = 0; a change of byte_mode mid-word has no effect until the next word.
REQ-035 When cnt reaches NB (or 1 in byte_mode), the assembled word SHALL be pushed on the next cycle with unused bytes set to zero, and cnt returns to 0.
REQ-036 A completed word arriving while the RX FIFO is full SHALL be dropped and rx_overflow set; FIFO contents stay unchanged.
REQ-037 On rx_ready with rx_ferr = 1, the block SHALL discard the byte and any partial word, set cnt = 0, and set rx_frame_err.
REQ-038 clear_err SHALL clear both sticky flags; if a set event occurs in the same cycle, set wins.
REQ-039 With NB = 1, byte_mode SHALL have no effect.

Reset
REQ-040 On rstn = 0 at a clock edge, the block SHALL empty both FIFOs, put the TX FSM in T_IDLE, and clear cnt and both flags.
REQ-041 Output reset values SHALL be: wr_ready = 1, rd_valid = 0, rd_data = 0, tx_start = 0, tx_byte = 0, rx_overflow = 0, rx_frame_err = 0.
REQ-042 Reset during a transfer SHALL abort it immediately with no further tx_start; a byte already handed to uart_tx is not recalled.

Structure
REQ-043 Package uart_io_pkg SHALL hold the TX state enum, the default DATA_W/DEPTH values, and the NB calculation.
REQ-044 Both FIFOs SHALL be instances of one sub-module, sync_fifo, with parameters (W, DEPTH) and ports push/pop/full/empty/din/dout.

Verification (DATA_W = 32, DEPTH = 4, uart_tx modelled with busy held 10 cycles)
REQ-045 LSB_FIRST = 1, write 0x11223344 -> tx_byte sequence 0x44, 0x33, 0x22, 0x11, each with a single tx_start pulse no earlier than busy falling.
REQ-046 byte_mode = 1, write 0xABCDEF5A -> exactly one tx_byte, 0x5A; then byte_mode = 0, write 0x01020304 -> four bytes.
REQ-047 RX bytes 0x78, 0x56, 0x34, 0x12 -> rd_valid with rd_data = 0x12345678; with LSB_FIRST = 0, the same bytes give 0x78563412.
REQ-048 Five complete RX words with rd_ready = 0 -> four words stored in order, rx_overflow = 1, fifth word absent; clear_err -> flag 0.
REQ-049 Bytes 0xAA, 0xBB, then a framing error, then 0x01, 0x02, 0x03, 0x04 -> single word 0x04030201, rx_frame_err = 1.
REQ-050 rstn low while in T_WAIT with 2 words queued -> no further tx_start, wr_ready = 1, rd_valid = 0, all flags 0.
